fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 87 ++++++++
 tb/tb_fetch_stage.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC selection with redirect/stall
// priority, and the IF/ID pipeline register fed from a combinational instruction memory.
module fetch_stage #(
   parameter int ADDR_W   = 8,
   parameter int RESET_PC = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   input  logic              jump,
   input  logic [ADDR_W-1:0] jump_target,
   input  logic              jr,
   input  logic [ADDR_W-1:0] jr_target,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [15:0]       imem_rdata,
   output logic [15:0]       ifid_inst,
   output logic [ADDR_W-1:0] ifid_pc1,
   output logic              ifid_valid
);

   localparam logic [ADDR_W-1:0] LP_RESET_PC = ADDR_W'(RESET_PC);

   logic [ADDR_W-1:0] r_pc;
   logic [15:0]       r_ifid_inst;
   logic [ADDR_W-1:0] r_ifid_pc1;
   logic              r_ifid_valid;

   logic [ADDR_W-1:0] w_pc_plus1;
   logic [ADDR_W-1:0] w_pc_next;
   logic [15:0]       w_inst_next;
   logic [ADDR_W-1:0] w_pc1_next;
   logic              w_valid_next;

   // Natural truncation gives the all-ones -> 0 wrap.
   assign w_pc_plus1 = r_pc + ADDR_W'(1);

   // Branch outranks stall because the branch resolves in execute, which is
   // older than the decode-stage hazard; jr/jump come from decode itself.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can
      // leave it unassigned and infer a latch.
      w_pc_next    = w_pc_plus1;
      w_inst_next  = imem_rdata;
      w_pc1_next   = w_pc_plus1;
      w_valid_next = 1'b1;
      if (branch_taken) begin
         w_pc_next    = branch_target;
         w_inst_next  = '0;
         w_pc1_next   = '0;
         w_valid_next = 1'b0;
      end else if (stall) begin
         w_pc_next    = r_pc;
         w_inst_next  = r_ifid_inst;
         w_pc1_next   = r_ifid_pc1;
         w_valid_next = r_ifid_valid;
      end else if (jr || jump) begin
         w_pc_next    = jr ? jr_target : jump_target;
         w_inst_next  = '0;
         w_pc1_next   = '0;
         w_valid_next = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (!rst_n) begin
         r_pc         <= LP_RESET_PC;
         r_ifid_inst  <= '0;
         r_ifid_pc1   <= '0;
         r_ifid_valid <= 1'b0;
      end else begin
         r_pc         <= w_pc_next;
         r_ifid_inst  <= w_inst_next;
         r_ifid_pc1   <= w_pc1_next;
         r_ifid_valid <= w_valid_next;
      end
   end

   assign imem_addr  = r_pc;
   assign ifid_inst  = r_ifid_inst;
   assign ifid_pc1   = r_ifid_pc1;
   assign ifid_valid = r_ifid_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, hand-written reset
// sequences, and randomized control against a behavioural next-state model.
module tb_fetch_stage;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        branch_taken;
   logic [7:0]  branch_target;
   logic        jump;
   logic [7:0]  jump_target;
   logic        jr;
   logic [7:0]  jr_target;
   logic [7:0]  imem_addr;
   logic [15:0] imem_rdata;
   logic [15:0] ifid_inst;
   logic [7:0]  ifid_pc1;
   logic        ifid_valid;

   logic [15:0] mem [0:255];

   int checks = 0;
   int errors = 0;

   fetch_stage #(.ADDR_W(8), .RESET_PC(0)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .stall        (stall),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .jump         (jump),
      .jump_target  (jump_target),
      .jr           (jr),
      .jr_target    (jr_target),
      .imem_addr    (imem_addr),
      .imem_rdata   (imem_rdata),
      .ifid_inst    (ifid_inst),
      .ifid_pc1     (ifid_pc1),
      .ifid_valid   (ifid_valid)
   );

   assign imem_rdata = mem[imem_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        stall;
      logic        bt;
      logic [7:0]  btgt;
      logic        jump;
      logic [7:0]  jtgt;
      logic        jr;
      logic [7:0]  jrtgt;
      logic [7:0]  e_pc;
      logic [15:0] e_inst;
      logic [7:0]  e_pc1;
      logic        e_valid;
   } vec_t;

   vec_t vecs [16];

   function automatic vec_t mk(input logic s, input logic b, input logic [7:0] bt,
                               input logic j, input logic [7:0] jt,
                               input logic r, input logic [7:0] rt,
                               input logic [7:0] pc, input logic [15:0] inst,
                               input logic [7:0] pc1, input logic v);
      vec_t x;
      x.stall = s;  x.bt = b;   x.btgt = bt;
      x.jump  = j;  x.jtgt = jt; x.jr = r; x.jrtgt = rt;
      x.e_pc  = pc; x.e_inst = inst; x.e_pc1 = pc1; x.e_valid = v;
      return x;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all(input string tag, input logic [7:0] pc, input logic [15:0] inst,
                            input logic [7:0] pc1, input logic v);
      check({tag, ".pc"},    32'(imem_addr),  32'(pc));
      check({tag, ".inst"},  32'(ifid_inst),  32'(inst));
      check({tag, ".pc1"},   32'(ifid_pc1),   32'(pc1));
      check({tag, ".valid"}, 32'(ifid_valid), 32'(v));
   endtask

   task automatic drive(input logic s, input logic b, input logic [7:0] bt,
                        input logic j, input logic [7:0] jt,
                        input logic r, input logic [7:0] rt);
      stall = s; branch_taken = b; branch_target = bt;
      jump = j;  jump_target = jt; jr = r; jr_target = rt;
   endtask

   // Reference model state: what PC and IF/ID should hold after each edge.
   logic [7:0]  m_pc;
   logic [15:0] m_inst;
   logic [7:0]  m_pc1;
   logic        m_valid;

   task automatic model_step();
      if (branch_taken) begin
         m_pc = branch_target;
         m_inst = 16'h0000; m_pc1 = 8'h00; m_valid = 1'b0;
      end else if (stall) begin
         // everything holds
      end else if (jr || jump) begin
         m_pc = jr ? jr_target : jump_target;
         m_inst = 16'h0000; m_pc1 = 8'h00; m_valid = 1'b0;
      end else begin
         m_inst  = mem[m_pc];
         m_pc1   = 8'((int'(m_pc) + 1) % 256);
         m_pc    = m_pc1;
         m_valid = 1'b1;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      drive(0, 0, 8'h00, 0, 8'h00, 0, 8'h00);
      for (int i = 0; i < 256; i++) mem[i] = 16'hC000 | 16'(i);
      mem[0] = 16'h1123; mem[1] = 16'h2456; mem[2] = 16'h3789; mem[3] = 16'h4ABC;

      //                 stall bt btgt  jmp jtgt  jr jrtgt   pc     inst      pc1   v
      vecs[0]  = mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h01, 16'h1123, 8'h01, 1);
      vecs[1]  = mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h02, 16'h2456, 8'h02, 1);
      vecs[2]  = mk(1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h02, 16'h2456, 8'h02, 1);
      vecs[3]  = mk(1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h02, 16'h2456, 8'h02, 1);
      vecs[4]  = mk(1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h02, 16'h2456, 8'h02, 1);
      vecs[5]  = mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h03, 16'h3789, 8'h03, 1);
      vecs[6]  = mk(0, 0, 8'h00, 1, 8'h40, 0, 8'h00, 8'h40, 16'h0000, 8'h00, 0);
      vecs[7]  = mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h41, 16'hC040, 8'h41, 1);
      vecs[8]  = mk(1, 1, 8'h10, 0, 8'h00, 1, 8'h20, 8'h10, 16'h0000, 8'h00, 0);
      vecs[9]  = mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h11, 16'hC010, 8'h11, 1);
      vecs[10] = mk(1, 0, 8'h00, 1, 8'h77, 0, 8'h00, 8'h11, 16'hC010, 8'h11, 1);
      vecs[11] = mk(0, 0, 8'h00, 1, 8'h30, 1, 8'h20, 8'h20, 16'h0000, 8'h00, 0);
      vecs[12] = mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h21, 16'hC020, 8'h21, 1);
      vecs[13] = mk(0, 1, 8'hFF, 0, 8'h00, 0, 8'h00, 8'hFF, 16'h0000, 8'h00, 0);
      vecs[14] = mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 16'hC0FF, 8'h00, 1);
      vecs[15] = mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h01, 16'h1123, 8'h01, 1);

      // Reset state, including an edge while reset is held.
      #3;
      check_all("reset", 8'h00, 16'h0000, 8'h00, 0);
      @(posedge clk); #1;
      check_all("reset_edge", 8'h00, 16'h0000, 8'h00, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed table.
      for (int i = 0; i < 16; i++) begin
         drive(vecs[i].stall, vecs[i].bt, vecs[i].btgt, vecs[i].jump, vecs[i].jtgt,
               vecs[i].jr, vecs[i].jrtgt);
         @(posedge clk); #1;
         check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_inst,
                   vecs[i].e_pc1, vecs[i].e_valid);
      end

      // Reach PC=0x55 with a valid instruction, then pulse reset between edges.
      drive(0, 1, 8'h54, 0, 8'h00, 0, 8'h00);
      @(posedge clk); #1;
      drive(0, 0, 8'h00, 0, 8'h00, 0, 8'h00);
      @(posedge clk); #1;
      check_all("pre_async", 8'h55, 16'hC054, 8'h55, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_all("async_rst", 8'h00, 16'h0000, 8'h00, 0);
      drive(1, 0, 8'h00, 1, 8'h99, 1, 8'h88);
      @(posedge clk); #1;
      check_all("rst_ignores_ctrl", 8'h00, 16'h0000, 8'h00, 0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(0, 0, 8'h00, 0, 8'h00, 0, 8'h00);
      @(posedge clk); #1;
      check_all("post_rst_fetch", 8'h01, 16'h1123, 8'h01, 1);

      // Randomized run against the model.
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      m_pc = 8'h00; m_inst = 16'h0000; m_pc1 = 8'h00; m_valid = 1'b0;
      for (int c = 0; c < 400; c++) begin
         drive($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, 8'($urandom),
               $urandom_range(0, 5) == 0, 8'($urandom),
               $urandom_range(0, 7) == 0, 8'($urandom));
         model_step();
         @(posedge clk); #1;
         check_all($sformatf("rand%0d", c), m_pc, m_inst, m_pc1, m_valid);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
